dm_lane_mem: RTL and testbench
==============================

Name: dm_lane_mem

Overview:
- Parametrised, byte-addressable 32-bit data memory for the single-cycle/multi-cycle datapath; the next generation of the byte-array data memory.
- Four byte lanes with byte enables; supports sb/sh/sw and lb/lbu/lh/lhu.
- Adds a valid/ready request port, a registered read response and misalignment error reporting.
- Replaces the combinational-read memory with a hardware clear sweep after reset.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2 and at least 4.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset via the sweep; 0 = skip the sweep (contents undefined).
- ADDR_W, localparam $clog2(DEPTH_WORDS)+2, byte-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 3 = word, 2 = reserved (error).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  in  32  PC of the issuing instruction; used by the trace only.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - busy=CLEAR_ON_RESET.
  - FSM state = CLEAR if CLEAR_ON_RESET, else IDLE; sweep index = 0.
- Reset asserted mid-sweep or mid-response: outputs return to reset values immediately, and the sweep restarts from word 0 after reset is released. Any pending response is dropped.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Write 0 to word[idx] each cycle; idx increments.
  - busy=1, req_ready=0.
  - After idx = DEPTH_WORDS-1 is written, go to IDLE.
  - Sweep length is exactly DEPTH_WORDS cycles.
- IDLE:
  - req_ready = !resp_valid || resp_ready.
  - Accept = req_valid && req_ready.
- Alignment rule:
  - half: error if addr[0]=1.
  - word: error if addr[1:0]!=0.
  - size 2: always an error.
  - An erroneous request performs no write and no trace, and returns resp_err=1 with resp_rdata=0.
- Store:
  - Byte enables are decoded from size and addr[1:0].
  - Data is replicated onto lanes, little-endian: byte at addr holds bits [7:0].
  - Memory is updated at the accept edge.
  - Response: resp_valid=1 on the next cycle, resp_rdata=0, resp_err=0.
- Load:
  - The word is read at the accept edge.
  - Lane select plus extension is registered into resp_rdata.
  - resp_valid=1 on the next cycle (latency 1).
  - Extension examples:
    - lb with byte 0x80 gives 0xFFFFFF80; lbu gives 0x00000080.
    - lh with half 0x8001 gives 0xFFFF8001; lhu gives 0x00008001.
- Response hold and throughput:
  - resp_valid stays high, and resp_rdata/resp_err stay stable, until resp_ready=1.
  - Back-to-back requests are accepted every cycle while resp_ready=1 (full throughput).
- Ordering: a store accepted in cycle N is visible to a load accepted in cycle N+1. No forwarding is needed because the write lands at edge N.
- Simultaneous resp_ready and new accept: the old response retires and the new response appears the next cycle, with no bubble.
- Address wrap: req_addr covers exactly DEPTH_WORDS*4 bytes, so no out-of-range case exists. A word access never straddles words because alignment is enforced.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: on each successful store at the accept edge, $display("@%h: *%h <= %h", req_pc, byte address zero-extended to 32 bits, store data zero-extended from its size to 32 bits).
- Undefined: no $display statements are compiled, and the logic is otherwise identical.

Decomposition:
- Package dm_pkg:
  - Size constants SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd3.
  - FSM state encoding ST_CLEAR, ST_IDLE.
  - Byte-enable decode function.
- One sub-module, dm_load_ext: combinational lane select plus sign/zero extension.
  - Inputs: 32-bit word, addr[1:0], size, unsigned.
  - Output: 32-bit value.
  - The top level registers its output.

Test Plan:
1. Reset, then release with DEPTH_WORDS=16 → busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1; load word 0x3C → 0x00000000.
2. sw 0x12345678 @0x10; then lb @0x11 → 0x00000056, lh @0x12 → 0x00001234, lw @0x10 → 0x12345678, each resp_valid one cycle after accept, back-to-back.
3. sb 0x80 @0x21; lb @0x21 → 0xFFFFFF80; lbu @0x21 → 0x00000080. sh 0x8001 @0x22; lh → 0xFFFF8001; lhu → 0x00008001.
4. lw @0x13, sh @0x05, size=2 @0x08 → resp_err=1 and resp_rdata=0 for each; a later lw of the affected words is unchanged.
5. Hold resp_ready=0 for 3 cycles with a load pending → resp_valid and data stable, req_ready=0; raising resp_ready gives same-cycle acceptance of the next request.
6. Assert reset mid-sweep (idx=7) and mid-response → resp_valid drops asynchronously, the sweep restarts at 0, and busy lasts the full DEPTH_WORDS cycles; with DM_TRACE_EN, sw 0xDEADBEEF @0x40 with pc 0x3000 prints "@00003000: *00000040 <= deadbeef".

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the lane-based data memory.
//   - access size codes (byte / half / reserved / word)
//   - controller state encoding
//   - byte-enable decode and misalignment helpers
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_RSVD = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dm_state_t;

    // Lanes touched by an aligned access of the given size at byte offset lo.
    // Lane i holds byte address (word base + i), i.e. little-endian.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Halves must sit on even addresses, words on multiples of four, and the
    // reserved size code is never legal.
    function automatic logic is_bad_access(input logic [1:0] size,
                                           input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: picks the addressed byte/half out of a 32-bit memory word and
// sign- or zero-extends it to 32 bits. Purely combinational; the caller
// registers the result.
// Ports:
//   word_in     in  32  raw memory word
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size code (dm_pkg SZ_*)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   value       out 32  extended load value (0 for the reserved size)
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend according to size.
    // Halves are only meaningful at offsets 0 and 2; misaligned halves are
    // discarded by the top level, so no special case is needed here.
    always_comb begin
        shifted = word_in >> {addr_lo, 3'b000};
        value   = '0;
        case (size)
            SZ_BYTE: value = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: value = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            SZ_WORD: value = word_in;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/dm_lane_mem.sv
// dm_lane_mem: byte-addressable 32-bit data memory with four byte lanes,
// a valid/ready request port, a registered (latency 1) response and
// misalignment / reserved-size error reporting. After reset a hardware
// sweep zeroes every word (when CLEAR_ON_RESET != 0) while busy is high.
//
// Optional feature macro: DM_TRACE_EN -- when defined, every successful
// store prints "@<pc>: *<addr> <= <data>" at its accept edge.
//
// Ports:
//   clk           in   1       clock, rising edge
//   reset         in   1       asynchronous active-high reset
//   req_valid     in   1       request present
//   req_ready     out  1       request accepted when req_valid also high
//   req_we        in   1       1 = store, 0 = load
//   req_size      in   2       0 byte, 1 half, 3 word, 2 reserved
//   req_unsigned  in   1       loads: 1 zero-extend, 0 sign-extend
//   req_addr      in   ADDR_W  byte address
//   req_wdata     in   32      right-aligned store data
//   req_pc        in   32      issuing PC (trace only)
//   resp_valid    out  1       response available
//   resp_ready    in   1       consumer takes the response
//   resp_rdata    out  32      extended load data, 0 for stores/errors
//   resp_err      out  1       misaligned or reserved-size request
//   busy          out  1       clear sweep in progress
module dm_lane_mem
    import dm_pkg::*;
#(
    parameter  int DEPTH_WORDS    = 1024,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int ADDR_W         = $clog2(DEPTH_WORDS) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    logic [31:0]      mem [DEPTH_WORDS];

    dm_state_t        state, state_next;
    logic [IDX_W-1:0] clr_idx, clr_idx_next;

    logic             accept;
    logic             req_err;
    logic             do_store;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       be;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rd_word;
    logic [31:0]      ld_value;

    assign word_idx = req_addr[ADDR_W-1:2];
    assign req_err  = is_bad_access(req_size, req_addr[1:0]);
    assign be       = byte_enables(req_size, req_addr[1:0]);
    assign accept   = req_valid && req_ready;
    assign do_store = accept && req_we && !req_err;
    assign rd_word  = mem[word_idx];

    // State and sweep-index register. Reset puts the controller back at the
    // start of the sweep (or straight into IDLE when clearing is disabled),
    // so an interrupted sweep always restarts from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // Next-state and handshake outputs. The sweep zeroes one word per cycle
    // and hands over to IDLE right after the last word, giving exactly
    // DEPTH_WORDS busy cycles. In IDLE a request can be taken whenever the
    // response slot is empty or is being drained this same cycle, which keeps
    // full throughput. req_ready is also forced low while reset is asserted.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        busy         = 1'b0;
        req_ready    = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy         = 1'b1;
                clr_idx_next = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = !reset && (!resp_valid || resp_ready);
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone decide
    // which bytes land; the lane position follows from the address.
    always_comb begin
        wdata_lanes = req_wdata;
        case (req_size)
            SZ_BYTE: wdata_lanes = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_lanes = {2{req_wdata[15:0]}};
            default: wdata_lanes = req_wdata;
        endcase
    end

    // Memory array write port: the sweep owns it during CLEAR, otherwise
    // accepted stores update only their enabled lanes at the accept edge so
    // a load accepted on the very next cycle already sees the new data.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (do_store) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    mem[word_idx][8*lane +: 8] <= wdata_lanes[8*lane +: 8];
                end
            end
        end
    end

    dm_load_ext u_load_ext (
        .word_in     (rd_word),
        .addr_lo     (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .value       (ld_value)
    );

    // Response register. A new accept always overwrites the slot (the old
    // response, if any, is retiring this cycle since req_ready required it).
    // Otherwise the response holds until the consumer takes it, then clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= req_err;
            resp_rdata <= (req_we || req_err) ? 32'h0 : ld_value;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] trace_data;

    // The traced value is the store data cut down to its access size.
    always_comb begin
        trace_data = req_wdata;
        case (req_size)
            SZ_BYTE: trace_data = {24'h0, req_wdata[7:0]};
            SZ_HALF: trace_data = {16'h0, req_wdata[15:0]};
            default: trace_data = req_wdata;
        endcase
    end

    // Trace successful stores at the edge that commits them.
    always_ff @(posedge clk) begin
        if (do_store) begin
            $display("@%h: *%h <= %h", req_pc, 32'(req_addr), trace_data);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_lane_mem.sv
// tb_dm_lane_mem: directed, self-checking bench for dm_lane_mem with a
// 16-word memory. Inputs change 1 time unit after the rising edge;
// registered outputs are sampled there, handshake outputs just before the
// following edge.
module tb_dm_lane_mem;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH) + 2;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   req_pc;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    dm_lane_mem #(
        .DEPTH_WORDS    (DEPTH),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case something stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [AW-1:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_pc       = 32'h0000_1000 + 32'(addr);
    endtask

    task automatic drop_req;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Outputs while reset is held.
    task automatic test_reset;
        logic [35:0] exp;
        reset = 1'b1;
        tick;
        tick;
        exp = {1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, busy} !== exp) begin
            failures++;
            $display("[TB] FAIL reset_values: got %h expected %h",
                     {req_ready, resp_valid, resp_err, resp_rdata, busy}, exp);
        end
    endtask

    // Sweep length after release, with a store offered during the sweep that
    // must be ignored, then a load of the last word.
    task automatic test_clear_sweep;
        int n;
        logic ready_seen;
        drive_req(1'b1, 2'd3, 1'b0, AW'(6'h3C), 32'hFFFF_FFFF);
        reset      = 1'b0;
        n          = 0;
        ready_seen = 1'b0;
        while (busy === 1'b1 && n < 64) begin
            if (req_ready !== 1'b0) ready_seen = 1'b1;
            tick;
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("[TB] FAIL sweep_length: got %0d cycles expected %0d", n, DEPTH);
        end
        checks++;
        if (ready_seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sweep_ready: req_ready got 1 during sweep expected 0");
        end
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL post_sweep_ready: got ready/valid=%b expected 10",
                     {req_ready, resp_valid});
        end
        drive_req(1'b0, 2'd3, 1'b0, AW'(6'h3C), 32'h0);
        tick;
        drop_req;
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL lw_0x3C_cleared: got v=%b e=%b d=%h expected v=1 e=0 d=00000000",
                     resp_valid, resp_err, resp_rdata);
        end
        tick;
    endtask

    // sw followed by three back-to-back loads, one response per cycle.
    task automatic test_store_load;
        logic [AW-1:0] addrs [4] = '{AW'(6'h10), AW'(6'h11), AW'(6'h12), AW'(6'h10)};
        logic [1:0]    sizes [4] = '{2'd3, 2'd0, 2'd1, 2'd3};
        logic [31:0]   exps  [4] = '{32'h0, 32'h0000_0056, 32'h0000_1234, 32'h1234_5678};
        for (int i = 0; i < 4; i++) begin
            drive_req(i == 0, sizes[i], 1'b0, addrs[i], 32'h1234_5678);
            checks++;
            if (req_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, req_ready);
            end
            tick;
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, exps[i]}) begin
                failures++;
                $display("[TB] FAIL b2b_resp_%0d: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
                         i, resp_valid, resp_err, resp_rdata, exps[i]);
            end
        end
        drop_req;
        tick;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_retire: resp_valid got %b expected 0", resp_valid);
        end
    endtask

    // Sub-word stores with junk in the upper bits, then signed/unsigned loads.
    task automatic test_extension;
        logic          wes   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]    sizes [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
        logic          unss  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [AW-1:0] addrs [7] = '{AW'(6'h21), AW'(6'h21), AW'(6'h21), AW'(6'h22),
                                     AW'(6'h22), AW'(6'h22), AW'(6'h20)};
        logic [31:0]   wds   [7] = '{32'hABCD_EF80, 32'h0, 32'h0, 32'h5555_8001,
                                     32'h0, 32'h0, 32'h0};
        logic [31:0]   exps  [7] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'h0,
                                     32'hFFFF_8001, 32'h0000_8001, 32'h8001_8000};
        for (int i = 0; i < 7; i++) begin
            drive_req(wes[i], sizes[i], unss[i], addrs[i], wds[i]);
            tick;
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, exps[i]}) begin
                failures++;
                $display("[TB] FAIL ext_%0d: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
                         i, resp_valid, resp_err, resp_rdata, exps[i]);
            end
        end
        drop_req;
        tick;
    endtask

    // Misaligned and reserved-size requests, then proof that nothing was written.
    task automatic test_errors;
        logic          wes   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]    sizes [7] = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [AW-1:0] addrs [7] = '{AW'(6'h13), AW'(6'h05), AW'(6'h08), AW'(6'h10),
                                     AW'(6'h10), AW'(6'h04), AW'(6'h08)};
        logic          errs  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0]   exps  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive_req(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_BEEF);
            tick;
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, errs[i], exps[i]}) begin
                failures++;
                $display("[TB] FAIL err_%0d: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
                         i, resp_valid, resp_err, resp_rdata, errs[i], exps[i]);
            end
        end
        drop_req;
        tick;
    endtask

    // Response held under back-pressure, then same-cycle acceptance on release.
    task automatic test_backpressure;
        resp_ready = 1'b0;
        drive_req(1'b0, 2'd3, 1'b0, AW'(6'h10), 32'h0);
        tick;
        drive_req(1'b0, 2'd3, 1'b0, AW'(6'h20), 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b1, 1'b0, 32'h1234_5678}) begin
                failures++;
                $display("[TB] FAIL hold_%0d: got rdy=%b v=%b e=%b d=%h expected rdy=0 v=1 e=0 d=12345678",
                         i, req_ready, resp_valid, resp_err, resp_rdata);
            end
            tick;
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_ready: got %b expected 1", req_ready);
        end
        tick;
        drop_req;
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h8001_8000}) begin
            failures++;
            $display("[TB] FAIL release_resp: got v=%b e=%b d=%h expected v=1 e=0 d=80018000",
                     resp_valid, resp_err, resp_rdata);
        end
        tick;
    endtask

    // Reset during a held response and again mid-sweep; memory comes back zeroed.
    task automatic test_reset_mid;
        int n;
        resp_ready = 1'b0;
        drive_req(1'b0, 2'd3, 1'b0, AW'(6'h10), 32'h0);
        tick;
        drop_req;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({resp_valid, resp_rdata, busy, req_ready} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_mid_resp: got v=%b d=%h busy=%b rdy=%b expected v=0 d=00000000 busy=1 rdy=0",
                     resp_valid, resp_rdata, busy, req_ready);
        end
        tick;
        reset      = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, req_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_mid_sweep: got busy/rdy=%b expected 10", {busy, req_ready});
        end
        tick;
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            tick;
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("[TB] FAIL restart_sweep_length: got %0d cycles expected %0d", n, DEPTH);
        end
        drive_req(1'b0, 2'd3, 1'b0, AW'(6'h10), 32'h0);
        tick;
        drop_req;
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL recleared_0x10: got v=%b e=%b d=%h expected v=1 e=0 d=00000000",
                     resp_valid, resp_err, resp_rdata);
        end
        tick;
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_pc       = '0;
        resp_ready   = 1'b1;
        test_reset;
        test_clear_sweep;
        test_store_load;
        test_extension;
        test_errors;
        test_backpressure;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
